// File: rtl/logic_pkg.sv
// Shared encodings for the bitwise data-processing unit and its barrel shifter.
package logic_pkg;

  typedef enum logic [2:0] {
    LOGIC_AND = 3'd0,
    LOGIC_EOR = 3'd1,
    LOGIC_ORR = 3'd2,
    LOGIC_BIC = 3'd3,
    LOGIC_MOV = 3'd4,
    LOGIC_MVN = 3'd5
  } logic_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_type_e;

endpackage

// File: rtl/op_logic_shift_shifter.sv
// ARM-style barrel shifter: LSL/LSR/ASR/ROR/RRX with immediate or register amount.
module barrel_shifter
  import logic_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 8
) (
  input  logic [DATA_W-1:0]  rm,
  input  logic [1:0]         stype,
  input  logic               shamt_reg,
  input  logic [4:0]         imm_shift,
  input  logic [SHAMT_W-1:0] rs_amt,
  input  logic               c_in,
  output logic [DATA_W-1:0]  op2,
  output logic               c_out
);

  logic [31:0]              amt;
  logic [31:0]              rot_amt;
  logic [DATA_W:0]          ext_l;
  logic [DATA_W:0]          ext_r;
  logic signed [DATA_W:0]   ext_a;
  logic [DATA_W-1:0]        rot;

  // The extra bit beside each shifted value catches the last bit shifted out,
  // which is the carry for any amount up to and beyond DATA_W.
  always_comb begin
    amt = shamt_reg ? 32'(rs_amt) : 32'(imm_shift);
    if (!shamt_reg && amt == 32'd0 && (stype == SH_LSR || stype == SH_ASR))
      amt = DATA_W;
    rot_amt = amt % DATA_W;
    ext_l   = {1'b0, rm} << amt;
    ext_r   = {rm, 1'b0} >> amt;
    ext_a   = $signed({rm, 1'b0}) >>> amt;
    rot     = (rm >> rot_amt) | (rm << (DATA_W - rot_amt));
    op2     = rm;
    c_out   = c_in;
    if (amt != 32'd0) begin
      case (shift_type_e'(stype))
        SH_LSL: begin op2 = ext_l[DATA_W-1:0]; c_out = ext_l[DATA_W]; end
        SH_LSR: begin op2 = ext_r[DATA_W:1];   c_out = ext_r[0];      end
        SH_ASR: begin op2 = ext_a[DATA_W:1];   c_out = ext_a[0];      end
        SH_ROR: begin op2 = rot;               c_out = rot[DATA_W-1]; end
      endcase
    end else if (!shamt_reg && stype == SH_ROR) begin
      op2   = {c_in, rm[DATA_W-1:1]};
      c_out = rm[0];
    end
  end

endmodule

// File: rtl/op_logic_shift.sv
// Two-stage execute unit for bitwise ops on Rn and a shifted/immediate operand.
module op_logic_shift
  import logic_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 12,
  parameter int unsigned SHAMT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_imm,
  input  logic              in_s,
  input  logic [DATA_W-1:0] in_rn,
  input  logic [DATA_W-1:0] in_rm,
  input  logic [IMM_W-1:0]  in_imm_operand,
  input  logic [1:0]        in_stype,
  input  logic              in_shamt_reg,
  input  logic [4:0]        in_imm_shift,
  input  logic [DATA_W-1:0] in_rs,
  input  logic              in_c,
  input  logic              in_z,
  input  logic              in_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd,
  output logic              out_c,
  output logic              out_z,
  output logic              out_n,
  output logic              out_flags_we
);

  logic              s1_valid_q, s1_valid_d;
  logic [2:0]        s1_op_q, s1_op_d;
  logic              s1_s_q, s1_s_d;
  logic [DATA_W-1:0] s1_rn_q, s1_rn_d;
  logic [DATA_W-1:0] s1_op2_q, s1_op2_d;
  logic              s1_sc_q, s1_sc_d;
  logic [2:0]        s1_czn_q, s1_czn_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_rd_q, s2_rd_d;
  logic              s2_c_q, s2_c_d;
  logic              s2_z_q, s2_z_d;
  logic              s2_n_q, s2_n_d;
  logic              s2_we_q, s2_we_d;

  logic              s2_can_load;
  logic [DATA_W-1:0] sh_op2;
  logic              sh_c;
  logic [DATA_W-1:0] rd_calc;

  barrel_shifter #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .rm       (in_rm),
    .stype    (in_stype),
    .shamt_reg(in_shamt_reg),
    .imm_shift(in_imm_shift),
    .rs_amt   (in_rs[SHAMT_W-1:0]),
    .c_in     (in_c),
    .op2      (sh_op2),
    .c_out    (sh_c)
  );

  assign s2_can_load = !s2_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || s2_can_load;

  always_comb begin
    case (s1_op_q)
      LOGIC_AND: rd_calc = s1_rn_q & s1_op2_q;
      LOGIC_EOR: rd_calc = s1_rn_q ^ s1_op2_q;
      LOGIC_ORR: rd_calc = s1_rn_q | s1_op2_q;
      LOGIC_BIC: rd_calc = s1_rn_q & ~s1_op2_q;
      LOGIC_MVN: rd_calc = ~s1_op2_q;
      default:   rd_calc = s1_op2_q;
    endcase
  end

  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_s_d     = s1_s_q;
    s1_rn_d    = s1_rn_q;
    s1_op2_d   = s1_op2_q;
    s1_sc_d    = s1_sc_q;
    s1_czn_d   = s1_czn_q;
    if (in_valid && in_ready) begin
      s1_op_d  = in_op;
      s1_s_d   = in_s;
      s1_rn_d  = in_rn;
      s1_op2_d = in_imm ? DATA_W'(in_imm_operand) : sh_op2;
      s1_sc_d  = in_imm ? in_c : sh_c;
      s1_czn_d = {in_c, in_z, in_n};
    end

    s2_valid_d = s2_can_load ? s1_valid_q : s2_valid_q;
    s2_rd_d    = s2_rd_q;
    s2_c_d     = s2_c_q;
    s2_z_d     = s2_z_q;
    s2_n_d     = s2_n_q;
    s2_we_d    = s2_we_q;
    if (s1_valid_q && s2_can_load) begin
      s2_rd_d = rd_calc;
      s2_we_d = s1_s_q;
      if (s1_s_q) begin
        s2_c_d = s1_sc_q;
        s2_z_d = (rd_calc == '0);
        s2_n_d = rd_calc[DATA_W-1];
      end else begin
        {s2_c_d, s2_z_d, s2_n_d} = s1_czn_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_s_q     <= 1'b0;
      s1_rn_q    <= '0;
      s1_op2_q   <= '0;
      s1_sc_q    <= 1'b0;
      s1_czn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_rd_q    <= '0;
      s2_c_q     <= 1'b0;
      s2_z_q     <= 1'b0;
      s2_n_q     <= 1'b0;
      s2_we_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_s_q     <= s1_s_d;
      s1_rn_q    <= s1_rn_d;
      s1_op2_q   <= s1_op2_d;
      s1_sc_q    <= s1_sc_d;
      s1_czn_q   <= s1_czn_d;
      s2_valid_q <= s2_valid_d;
      s2_rd_q    <= s2_rd_d;
      s2_c_q     <= s2_c_d;
      s2_z_q     <= s2_z_d;
      s2_n_q     <= s2_n_d;
      s2_we_q    <= s2_we_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_rd       = s2_rd_q;
  assign out_c        = s2_c_q;
  assign out_z        = s2_z_q;
  assign out_n        = s2_n_q;
  assign out_flags_we = s2_we_q;

endmodule
